line_prefetch: RTL and testbench

//  Pixel source feeding vga_driver's COLOR_DATA_IN. Prefetches the next visible line from word-wide

---
 rtl/line_prefetch_pkg.sv | 52 +++++
 rtl/line_ram_dp.sv | 23 ++
 rtl/line_prefetch.sv | 160 ++++++++++++++++
 tb/tb_line_prefetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_prefetch_pkg.sv
// Shared constants and types for the VGA line prefetcher: raster geometry,
// RGB332 field layout, fetch FSM states and the read-pipeline tag.
package line_prefetch_pkg;

   localparam int unsigned H_ACTIVE_DEF   = 640;
   localparam int unsigned V_ACTIVE_DEF   = 480;
   localparam int unsigned WORDS_PER_LINE = H_ACTIVE_DEF / 4;

   localparam int unsigned R_LSB = 5;
   localparam int unsigned R_W   = 3;
   localparam int unsigned G_LSB = 2;
   localparam int unsigned G_W   = 3;
   localparam int unsigned B_LSB = 0;
   localparam int unsigned B_W   = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FETCH = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [R_W-1:0] r;
      logic [G_W-1:0] g;
      logic [B_W-1:0] b;
   } rgb332_t;

   // Sideband carried alongside the line RAM read
   typedef struct packed {
      logic [1:0] sel;
      logic       blank;
   } rd_tag_t;

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] sel);
      logic [7:0] b;
      case (sel)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

   function automatic rgb332_t to_rgb332(input logic [7:0] p);
      rgb332_t c;
      c.r = p[R_LSB +: R_W];
      c.g = p[G_LSB +: G_W];
      c.b = p[B_LSB +: B_W];
      return c;
   endfunction

endpackage

// File: rtl/line_ram_dp.sv
// Simple dual-port line buffer: one synchronous write port, one synchronous
// read port, no reset so it maps onto block RAM.
module line_ram_dp #(
   parameter int unsigned DEPTH = 320,
   parameter int unsigned AW    = 9,
   parameter int unsigned DW    = 32
) (
   input  logic          CLK_25MHz,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge CLK_25MHz) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/line_prefetch.sv
// VGA pixel source: prefetches the next visible line from word-wide frame
// memory into a double-buffered line RAM and serves RGB332 pixels with 2-cycle latency.
module line_prefetch
   import line_prefetch_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = WORDS_PER_LINE * 4,
   parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
   parameter int unsigned ADDR_W    = 17,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              CLK_25MHz,
   input  logic              RESET_N,
   input  logic [9:0]        CURX,
   input  logic [8:0]        CURY,
   input  logic              HBLANK,
   input  logic              VBLANK,
   input  logic              BLANK,
   output logic              MEM_REQ,
   output logic [ADDR_W-1:0] MEM_ADDR,
   input  logic              MEM_ACK,
   input  logic [31:0]       MEM_DATA,
   output logic [7:0]        COLOR_OUT,
   output logic              UNDERRUN
);

   localparam int unsigned WORDS  = H_ACTIVE / 4;
   localparam int unsigned WORD_W = $clog2(WORDS);
   localparam int unsigned RAM_AW = $clog2(2 * WORDS);

   fetch_state_e      state_q, state_d;
   logic              hblank_q, vblank_q;
   logic [WORD_W-1:0] word_q, word_d;
   logic              buf_q, buf_d;
   logic              req_d, underrun_d;
   logic [ADDR_W-1:0] addr_d;

   logic              trig_c;
   logic [8:0]        trig_line_c;
   logic [9:0]        next_line_c;
   logic [ADDR_W-1:0] line_base_c;

   logic              wr_en_c;
   logic [RAM_AW-1:0] wr_addr_c, rd_addr_c;
   logic [31:0]       rd_data;
   rd_tag_t           tag_q;
   rgb332_t           pix_c;

   // Trigger decode from the blanking edges; a VBLANK rise outranks an HBLANK fall
   always_comb begin
      trig_c      = 1'b0;
      trig_line_c = '0;
      next_line_c = 10'(CURY) + 10'd1;
      if (VBLANK && !vblank_q) begin
         trig_c = 1'b1;
      end else if (!HBLANK && hblank_q && !VBLANK && (next_line_c != 10'(V_ACTIVE))) begin
         trig_c      = 1'b1;
         trig_line_c = next_line_c[8:0];
      end
   end

   assign line_base_c = ADDR_W'(BASE_ADDR) + ADDR_W'(trig_line_c) * ADDR_W'(WORDS);

   // Fetch FSM next-state; a trigger while fetching restarts on the new line
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      buf_d      = buf_q;
      req_d      = MEM_REQ;
      addr_d     = MEM_ADDR;
      underrun_d = UNDERRUN;
      wr_en_c    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (trig_c) begin
               word_d  = '0;
               buf_d   = trig_line_c[0];
               addr_d  = line_base_c;
               req_d   = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (MEM_ACK) begin
               wr_en_c = 1'b1;
               if (word_q == WORD_W'(WORDS - 1)) begin
                  req_d   = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  word_d = word_q + WORD_W'(1);
                  addr_d = MEM_ADDR + ADDR_W'(1);
               end
            end
            if (trig_c) begin
               underrun_d = 1'b1;
               word_d     = '0;
               buf_d      = trig_line_c[0];
               addr_d     = line_base_c;
               req_d      = 1'b1;
               state_d    = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK_25MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= ST_IDLE;
         word_q   <= '0;
         buf_q    <= 1'b0;
         MEM_REQ  <= 1'b0;
         MEM_ADDR <= '0;
         UNDERRUN <= 1'b0;
         hblank_q <= 1'b1;
         vblank_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         buf_q    <= buf_d;
         MEM_REQ  <= req_d;
         MEM_ADDR <= addr_d;
         UNDERRUN <= underrun_d;
         hblank_q <= HBLANK;
         vblank_q <= VBLANK;
      end
   end

   // Buffer b occupies words [b*WORDS, b*WORDS+WORDS)
   assign wr_addr_c = buf_q   ? RAM_AW'(WORDS) + RAM_AW'(word_q)    : RAM_AW'(word_q);
   assign rd_addr_c = CURY[0] ? RAM_AW'(WORDS) + RAM_AW'(CURX[9:2]) : RAM_AW'(CURX[9:2]);

   line_ram_dp #(
      .DEPTH (2 * WORDS),
      .AW    (RAM_AW),
      .DW    (32)
   ) u_ram (
      .CLK_25MHz (CLK_25MHz),
      .wr_en     (wr_en_c),
      .wr_addr   (wr_addr_c),
      .wr_data   (MEM_DATA),
      .rd_addr   (rd_addr_c),
      .rd_data   (rd_data)
   );

   assign pix_c = to_rgb332(byte_sel(rd_data, tag_q.sel));

   // Read pipeline: byte select and blank travel with the RAM read
   always_ff @(posedge CLK_25MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         tag_q     <= '0;
         COLOR_OUT <= '0;
      end else begin
         tag_q.sel   <= CURX[1:0];
         tag_q.blank <= BLANK;
         if (tag_q.blank) COLOR_OUT <= '0;
         else             COLOR_OUT <= pix_c;
      end
   end

endmodule

// File: tb/tb_line_prefetch.sv
// Self-checking bench for line_prefetch: memory responder with a line-level
// reference model, table-driven pixel vectors and multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_line_prefetch;

   localparam int WORDS = 160;

   logic        CLK_25MHz = 1'b0;
   logic        RESET_N   = 1'b0;
   logic [9:0]  CURX      = '0;
   logic [8:0]  CURY      = '0;
   logic        HBLANK    = 1'b1;
   logic        VBLANK    = 1'b1;
   logic        BLANK     = 1'b0;
   logic        MEM_REQ;
   logic [16:0] MEM_ADDR;
   logic        MEM_ACK   = 1'b0;
   logic [31:0] MEM_DATA  = '0;
   logic [7:0]  COLOR_OUT;
   logic        UNDERRUN;

   line_prefetch dut (
      .CLK_25MHz (CLK_25MHz),
      .RESET_N   (RESET_N),
      .CURX      (CURX),
      .CURY      (CURY),
      .HBLANK    (HBLANK),
      .VBLANK    (VBLANK),
      .BLANK     (BLANK),
      .MEM_REQ   (MEM_REQ),
      .MEM_ADDR  (MEM_ADDR),
      .MEM_ACK   (MEM_ACK),
      .MEM_DATA  (MEM_DATA),
      .COLOR_OUT (COLOR_OUT),
      .UNDERRUN  (UNDERRUN)
   );

   initial forever #20 CLK_25MHz = ~CLK_25MHz;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int errors = 0;
   int checks = 0;

   // Reference model state
   int        ack_mode = 1;     // 0 withhold, 1 every cycle, 2 random
   bit        exp_active = 1'b0;
   int        exp_base = 0;
   int        exp_buf = 0;
   int        ack_cnt = 0;
   bit        exp_underrun = 1'b0;
   bit        h_prev = 1'b1;
   bit        v_prev = 1'b1;
   bit [31:0] bm_ram [2][WORDS];

   typedef struct {
      int       cury;
      int       curx;
      bit       blank;
      bit [7:0] exp;
   } vec_t;
   vec_t vecs[8];

   function automatic bit [31:0] mem_word(input int a);
      if (a == 961) return 32'hDDCCBBAA;
      return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic bit [7:0] exp_pix(input int cury, input int curx, input bit blank);
      bit [31:0] w;
      if (blank) return 8'h00;
      w = bm_ram[cury % 2][curx / 4];
      return w[8 * (curx % 4) +: 8];
   endfunction

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock: advance past the edge, then play the memory side
   task automatic tick();
      @(posedge CLK_25MHz);
      #1;
      MEM_ACK = 1'b0;
      if (RESET_N) begin
         if (!exp_active) begin
            chk("idle_req", MEM_REQ, 0);
         end else if (MEM_REQ && (ack_mode == 1 || (ack_mode == 2 && $urandom_range(1, 0) == 1))) begin
            chk("fetch_addr", MEM_ADDR, exp_base + ack_cnt);
            bm_ram[exp_buf][ack_cnt] = mem_word(exp_base + ack_cnt);
            MEM_DATA = mem_word(int'(MEM_ADDR));
            MEM_ACK  = 1'b1;
            ack_cnt++;
            if (ack_cnt == WORDS) exp_active = 1'b0;
         end
      end
   endtask

   // Drive blanking/line inputs and predict any fetch they trigger
   task automatic drive(input bit h, input bit v, input int cury);
      bit trig;
      int tgt;
      trig = 1'b0;
      tgt  = 0;
      if (v && !v_prev) begin
         trig = 1'b1;
      end else if (!h && h_prev && !v && (cury + 1 != 480)) begin
         trig = 1'b1;
         tgt  = cury + 1;
      end
      if (trig) begin
         if (exp_active) exp_underrun = 1'b1;
         exp_active = 1'b1;
         exp_base   = tgt * WORDS;
         exp_buf    = tgt % 2;
         ack_cnt    = 0;
      end
      HBLANK = h;
      VBLANK = v;
      CURY   = 9'(cury);
      h_prev = h;
      v_prev = v;
   endtask

   task automatic wait_fetch(input string name);
      int n;
      n = 0;
      while (exp_active && n < 3000) begin
         tick();
         n++;
      end
      chk({name, "_complete"}, exp_active, 0);
      tick();
      chk({name, "_req_low"}, MEM_REQ, 0);
      chk({name, "_underrun"}, UNDERRUN, exp_underrun);
   endtask

   task automatic check_pix(input int cury, input int curx, input bit blank,
                            input bit [7:0] exp, input string name);
      CURY  = 9'(cury);
      CURX  = 10'(curx);
      BLANK = blank;
      tick();
      tick();
      chk(name, COLOR_OUT, exp);
   endtask

   initial begin
      bit [31:0] w0, w159;
      int n, cy, cx;
      bit bl;

      w0   = mem_word(960);
      w159 = mem_word(1119);
      vecs[0] = '{6, 6,   1'b0, 8'hCC};
      vecs[1] = '{6, 4,   1'b0, 8'hAA};
      vecs[2] = '{6, 5,   1'b0, 8'hBB};
      vecs[3] = '{6, 7,   1'b0, 8'hDD};
      vecs[4] = '{6, 6,   1'b1, 8'h00};
      vecs[5] = '{6, 0,   1'b0, w0[7:0]};
      vecs[6] = '{6, 639, 1'b0, w159[31:24]};
      vecs[7] = '{8, 3,   1'b0, w0[31:24]};

      // Reset held with toggling inputs
      for (int i = 0; i < 8; i++) begin
         @(posedge CLK_25MHz);
         #1;
         CURX     = 10'($urandom_range(639, 0));
         CURY     = 9'($urandom_range(479, 0));
         HBLANK   = 1'($urandom);
         VBLANK   = 1'($urandom);
         BLANK    = 1'($urandom);
         MEM_ACK  = 1'($urandom);
         MEM_DATA = $urandom;
         #5;
         chk("rst_req", MEM_REQ, 0);
         chk("rst_color", COLOR_OUT, 0);
         chk("rst_underrun", UNDERRUN, 0);
      end
      HBLANK  = 1'b1;
      VBLANK  = 1'b1;
      BLANK   = 1'b0;
      MEM_ACK = 1'b0;
      tick();
      RESET_N = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("post_rst_underrun", UNDERRUN, 0);

      // VBLANK rise fetches line 0 into buffer 0
      ack_mode = 1;
      drive(1'b1, 1'b0, 0);
      tick();
      drive(1'b1, 1'b1, 0);
      wait_fetch("line0");
      for (int i = 0; i < 8; i++) begin
         cy = 2 * $urandom_range(239, 0);
         cx = $urandom_range(639, 0);
         check_pix(cy, cx, 1'b0, exp_pix(cy, cx, 1'b0), "line0_pix");
      end

      // HBLANK fall on line 5 fetches line 6 (960..1119) into buffer 0
      drive(1'b1, 1'b0, 5);
      tick();
      drive(1'b0, 1'b0, 5);
      wait_fetch("line6");
      drive(1'b1, 1'b0, 6);
      tick();
      foreach (vecs[i]) check_pix(vecs[i].cury, vecs[i].curx, vecs[i].blank, vecs[i].exp, "vec_pix");

      // Last visible line: no fetch; blanked pixel is zero
      drive(1'b1, 1'b0, 479);
      tick();
      drive(1'b0, 1'b0, 479);
      for (int i = 0; i < 20; i++) tick();
      chk("no_fetch_479", MEM_REQ, 0);
      check_pix(479, 100, 1'b1, 8'h00, "blank_479");

      // Line 7 into buffer 1 with random ACK gaps, then random pixel reads
      drive(1'b1, 1'b0, 6);
      tick();
      ack_mode = 2;
      drive(1'b0, 1'b0, 6);
      wait_fetch("line7");
      for (int i = 0; i < 40; i++) begin
         cy = $urandom_range(479, 0);
         cx = $urandom_range(639, 0);
         bl = ($urandom_range(3, 0) == 0);
         check_pix(cy, cx, bl, exp_pix(cy, cx, bl), "rand_pix");
      end

      // ACK withheld past the next trigger -> sticky underrun and restart
      ack_mode = 0;
      drive(1'b1, 1'b0, 20);
      tick();
      drive(1'b0, 1'b0, 20);
      for (int i = 0; i < 900; i++) tick();
      chk("stall_req", MEM_REQ, 1);
      chk("stall_addr", MEM_ADDR, 21 * WORDS);
      chk("stall_underrun", UNDERRUN, 0);
      drive(1'b1, 1'b0, 9);
      tick();
      drive(1'b0, 1'b0, 9);
      tick();
      tick();
      chk("underrun_set", UNDERRUN, exp_underrun);
      chk("restart_req", MEM_REQ, 1);
      chk("restart_addr", MEM_ADDR, 10 * WORDS);
      ack_mode = 1;
      wait_fetch("line10");
      chk("underrun_sticky", UNDERRUN, 1);

      // Reset in the middle of a fetch
      drive(1'b1, 1'b0, 9);
      tick();
      drive(1'b1, 1'b1, 9);
      n = 0;
      while (ack_cnt < 41 && n < 500) begin
         tick();
         n++;
      end
      chk("mid_fetch_reached", ack_cnt, 41);
      #1;
      RESET_N = 1'b0;
      #1;
      chk("mid_rst_req", MEM_REQ, 0);
      chk("mid_rst_underrun", UNDERRUN, 0);
      exp_active   = 1'b0;
      exp_underrun = 1'b0;
      MEM_ACK      = 1'b0;
      HBLANK       = 1'b1;
      VBLANK       = 1'b1;
      h_prev       = 1'b1;
      v_prev       = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      RESET_N = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("post_mid_rst_req", MEM_REQ, 0);
      drive(1'b1, 1'b0, 0);
      tick();
      drive(1'b1, 1'b1, 0);
      wait_fetch("refetch0");
      check_pix(0, 0, 1'b0, exp_pix(0, 0, 1'b0), "refetch_pix0");
      check_pix(2, 163, 1'b0, exp_pix(2, 163, 1'b0), "refetch_pix40");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
